mem_arbiter: RTL

Single-port memory arbiter between the MIPS core's instruction-fetch port and data port. It lets one unified, variable-latency memory serve both. It accepts request/acknowledge transactions from the two requesters and grants one at a time. It drives one registered memory transaction per grant and returns read data, completion and error status to the granted requester. A timeout aborts any transaction the memory never acknowledges.

---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arb_timer.sv | 32 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS core memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } MEM_ARB_STATE;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } MEM_ARB_PORT;

    // Cycles a transaction may wait for mem_ack before it is aborted.
    localparam int unsigned MEM_ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and unified memory port bundled for the arbiter.
// Latency: n/a (wires only).
// Backpressure: req held until ack; mem_req held until mem_ack or abort.
interface mem_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic        i_err;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // Arbiter view.
    modport slave (
        input  i_req, i_addr,
        output i_ack, i_err, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ack, d_err, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    // Requesters plus memory view.
    modport master (
        output i_req, i_addr,
        input  i_ack, i_err, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ack, d_err, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_arb_timer.sv
// Wait counter for an outstanding memory transaction; flags the abort cycle.
// Latency: expired is combinational from the registered count.
// Backpressure: none; counts while enabled, cleared while idle.
module mem_arb_timer
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MEM_ARB_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count busy cycles; the abort fires before the count could wrap.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Grants one of fetch/data ports onto a single variable-latency memory; MEM_ARB_RR_EN selects round-robin.
// Latency: req->mem_req 1 cycle, mem_ack->x_ack 1 cycle, minimum req->ack 2 cycles; all outputs registered.
// Backpressure: one transaction in flight; other port waits with req held; timeout aborts with err.
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MEM_ARB_TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    MEM_ARB_STATE state;
    logic         expired;
    logic         i_elig;
    logic         d_elig;
    logic         pick_i;
    logic         pick_d;

`ifdef MEM_ARB_RR_EN
    MEM_ARB_PORT  last_grant;
`endif

    mem_arb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == IDLE),
        .enable  (state != IDLE),
        .expired (expired)
    );

    // A port whose ack is currently high must not be granted again on a stale req.
    always_comb begin
        i_elig = bus.i_req && !bus.i_ack;
        d_elig = bus.d_req && !bus.d_ack;
`ifdef MEM_ARB_RR_EN
        pick_d = d_elig && (!i_elig || (last_grant == PORT_I));
`else
        pick_d = d_elig;
`endif
        pick_i = i_elig && !pick_d;
    end

    // Arbitration FSM; drives every output from a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.i_ack     <= 1'b0;
            bus.i_err     <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_ack     <= 1'b0;
            bus.d_err     <= 1'b0;
            bus.d_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant    <= PORT_I;
`endif
        end else begin
            bus.i_ack <= 1'b0;
            bus.i_err <= 1'b0;
            bus.d_ack <= 1'b0;
            bus.d_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.d_we;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_wdata <= bus.d_wdata;
                        state         <= BUSY_D;
`ifdef MEM_ARB_RR_EN
                        last_grant    <= PORT_D;
`endif
                    end else if (pick_i) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.i_addr;
                        bus.mem_wdata <= '0;
                        state         <= BUSY_I;
`ifdef MEM_ARB_RR_EN
                        last_grant    <= PORT_I;
`endif
                    end
                end
                BUSY_I: begin
                    if (bus.mem_ack) begin
                        bus.i_rdata <= bus.mem_rdata;
                        bus.i_ack   <= 1'b1;
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                    end else if (expired) begin
                        bus.i_rdata <= '0;
                        bus.i_ack   <= 1'b1;
                        bus.i_err   <= 1'b1;
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ack) begin
                        bus.d_rdata <= bus.mem_rdata;
                        bus.d_ack   <= 1'b1;
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                    end else if (expired) begin
                        bus.d_rdata <= '0;
                        bus.d_ack   <= 1'b1;
                        bus.d_err   <= 1'b1;
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    bus.mem_req <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
